// File: rtl/fft_pkg.sv
// Shared constants, lane sample types and the Q1.10 twiddle generator used by the 512-point FFT stages.
package fft_pkg;
  localparam int FFT_N   = 512;
  localparam int TW_FRAC = 10;
  localparam int TW_W    = 12;
  localparam int IN_W    = 15;
  localparam int OUT_W   = 15;
  localparam int ADDR_W  = $clog2(FFT_N);
  localparam int QTR_W   = ADDR_W - 2;

  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint ONE_Q30 = 64'sd1073741824;
  localparam longint HALF_Q  = 64'sd1 <<< (30 - TW_FRAC - 1);

  typedef logic signed [IN_W-1:0]  sample_in_t;
  typedef logic signed [OUT_W-1:0] sample_out_t;

  typedef struct packed {
    logic signed [TW_W-1:0] c;
    logic signed [TW_W-1:0] s;
  } twiddle_t;

  // Elaboration-time cos/sin: Taylor series on the first-quadrant residue, then quadrant symmetry.
  function automatic twiddle_t twiddle_calc(input logic [ADDR_W-1:0] idx);
    longint   x;
    longint   x2;
    longint   t;
    longint   cs;
    longint   sn;
    longint   cr;
    longint   sr;
    longint   cv;
    longint   sv;
    twiddle_t tw;
    x  = (longint'(idx[QTR_W-1:0]) * PI_Q30) >>> (ADDR_W - 1);
    x2 = (x * x) >>> 30;
    t  = ONE_Q30;
    cs = t;
    for (int k = 1; k <= 10; k++) begin
      t  = -((t * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
      cs = cs + t;
    end
    t  = x;
    sn = x;
    for (int k = 1; k <= 10; k++) begin
      t  = -((t * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sn = sn + t;
    end
    cr = (cs + HALF_Q) >>> (30 - TW_FRAC);
    sr = (sn + HALF_Q) >>> (30 - TW_FRAC);
    case (idx[ADDR_W-1:QTR_W])
      2'd0:    begin cv = cr;  sv = sr;  end
      2'd1:    begin cv = -sr; sv = cr;  end
      2'd2:    begin cv = -cr; sv = -sr; end
      2'd3:    begin cv = sr;  sv = -cr; end
      default: begin cv = 64'sd0; sv = 64'sd0; end
    endcase
    tw.c = cv[TW_W-1:0];
    tw.s = sv[TW_W-1:0];
    return tw;
  endfunction
endpackage

// File: rtl/twiddle_rom.sv
// 512-entry constant twiddle table {c, s} in Q1.10, indexed by exponent e, with a registered output.
module twiddle_rom
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output twiddle_t          tw
);
  twiddle_t rom_s [FFT_N];
  twiddle_t tw_r;

  for (genvar k = 0; k < FFT_N; k++) begin : g_tab
    localparam twiddle_t TW_K = twiddle_calc(ADDR_W'(k));
    assign rom_s[k] = TW_K;
  end

  // Registered table lookup
  always_ff @(posedge clk) begin
    tw_r <= rom_s[addr];
  end

  assign tw = tw_r;
endmodule

// File: rtl/twiddle_mul_stage1.sv
// First-stage twiddle multiplier: each lane is rotated by W^e, 3-cycle latency, one beat per cycle.
// Define TWIDDLE_SAT_EN to clamp out-of-range results instead of wrapping them.
module twiddle_mul_stage1
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = 15,
  parameter int OUT_WIDTH = 15,
  parameter int TW_WIDTH  = 12,
  parameter int NUM       = 16,
  parameter int DATA      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM-1:0][IN_WIDTH-1:0]     din_i,
  input  logic [NUM-1:0][IN_WIDTH-1:0]     din_q,
  input  logic                             valid_in,
  output logic [NUM-1:0][OUT_WIDTH-1:0]    do_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]    do_im,
  output logic                             valid_out,
  output logic                             frame_start
);
  localparam int CNT_W = $clog2(DATA);
  localparam int PW    = IN_WIDTH + TW_WIDTH;
  localparam int SW    = PW + 1;
  localparam int RW    = SW - TW_FRAC;
  localparam logic signed [SW-1:0] RND_C = SW'(64'sd1 <<< (TW_FRAC - 1));

  logic [CNT_W-1:0] cnt_r;
  logic             v1_r;
  logic             fs1_r;
  logic             v2_r;
  logic             fs2_r;
  logic             valid_out_r;
  logic             frame_start_r;

  function automatic logic [OUT_WIDTH-1:0] fit_out(input logic [RW-1:0] v);
`ifdef TWIDDLE_SAT_EN
    if ((&v[RW-1:OUT_WIDTH-1]) || (~|v[RW-1:OUT_WIDTH-1])) fit_out = v[OUT_WIDTH-1:0];
    else if (v[RW-1]) fit_out = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else fit_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    fit_out = OUT_WIDTH'(v);
`endif
  endfunction

  // Beat counter plus valid / frame-start pipeline alongside the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= '0;
      v1_r          <= 1'b0;
      fs1_r         <= 1'b0;
      v2_r          <= 1'b0;
      fs2_r         <= 1'b0;
      valid_out_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      if (valid_in) cnt_r <= (cnt_r == CNT_W'(DATA - 1)) ? '0 : cnt_r + CNT_W'(1);
      v1_r          <= valid_in;
      fs1_r         <= valid_in && (cnt_r == '0);
      v2_r          <= v1_r;
      fs2_r         <= fs1_r;
      valid_out_r   <= v2_r;
      frame_start_r <= fs2_r;
    end
  end

  assign valid_out   = valid_out_r;
  assign frame_start = frame_start_r;

  for (genvar l = 0; l < NUM; l++) begin : g_lane
    logic [ADDR_W-1:0]          n_s;
    logic [ADDR_W-1:0]          e_s;
    twiddle_t                   tw_s;
    logic signed [IN_WIDTH-1:0] a_r;
    logic signed [IN_WIDTH-1:0] b_r;
    logic signed [PW-1:0]       a_x;
    logic signed [PW-1:0]       b_x;
    logic signed [PW-1:0]       c_x;
    logic signed [PW-1:0]       s_x;
    logic signed [PW-1:0]       ac_r;
    logic signed [PW-1:0]       bs_r;
    logic signed [PW-1:0]       bc_r;
    logic signed [PW-1:0]       as_r;
    logic signed [SW-1:0]       re_sum_s;
    logic signed [SW-1:0]       im_sum_s;
    logic signed [RW-1:0]       re_rnd_s;
    logic signed [RW-1:0]       im_rnd_s;
    logic [OUT_WIDTH-1:0]       re_out_r;
    logic [OUT_WIDTH-1:0]       im_out_r;

    // e = (n mod 128) * (n div 128), never exceeds 381
    assign n_s = ADDR_W'(int'(cnt_r) * NUM + l);
    assign e_s = {2'b00, n_s[QTR_W-1:0]} * {{QTR_W{1'b0}}, n_s[ADDR_W-1:QTR_W]};

    twiddle_rom u_rom (
      .clk  (clk),
      .addr (e_s),
      .tw   (tw_s)
    );

    // Stage 1: sample capture, aligned with the registered ROM output
    always_ff @(posedge clk) begin
      if (valid_in) begin
        a_r <= din_i[l];
        b_r <= din_q[l];
      end
    end

    assign a_x = PW'(a_r);
    assign b_x = PW'(b_r);
    assign c_x = PW'($signed(tw_s.c));
    assign s_x = PW'($signed(tw_s.s));

    // Stage 2: four full-precision partial products
    always_ff @(posedge clk) begin
      ac_r <= a_x * c_x;
      bs_r <= b_x * s_x;
      bc_r <= b_x * c_x;
      as_r <= a_x * s_x;
    end

    assign re_sum_s = SW'(ac_r) + SW'(bs_r);
    assign im_sum_s = SW'(bc_r) - SW'(as_r);
    assign re_rnd_s = RW'((re_sum_s + RND_C) >>> TW_FRAC);
    assign im_rnd_s = RW'((im_sum_s + RND_C) >>> TW_FRAC);

    // Stage 3: rounded result register, held while no beat completes
    always_ff @(posedge clk) begin
      if (rst) begin
        re_out_r <= '0;
        im_out_r <= '0;
      end else if (v2_r) begin
        re_out_r <= fit_out(re_rnd_s);
        im_out_r <= fit_out(im_rnd_s);
      end
    end

    assign do_re[l] = re_out_r;
    assign do_im[l] = im_out_r;
  end
endmodule

// File: tb/tb_twiddle_mul_stage1.sv
// Directed bench for twiddle_mul_stage1 with a floating-point reference model of the rotation.
module tb_twiddle_mul_stage1;
  localparam int NUM = 16;
  localparam int IW  = 15;
  localparam int OW  = 15;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM-1:0][IW-1:0] din_i;
  logic [NUM-1:0][IW-1:0] din_q;
  logic                   valid_in;
  logic [NUM-1:0][OW-1:0] do_re;
  logic [NUM-1:0][OW-1:0] do_im;
  logic                   valid_out;
  logic                   frame_start;

  always #5 clk = ~clk;

  twiddle_mul_stage1 dut (
    .clk         (clk),
    .rst         (rst),
    .din_i       (din_i),
    .din_q       (din_q),
    .valid_in    (valid_in),
    .do_re       (do_re),
    .do_im       (do_im),
    .valid_out   (valid_out),
    .frame_start (frame_start)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_v  [3];
  int m_fs [3];
  int m_re [3][NUM];
  int m_im [3][NUM];
  int last_re [NUM];
  int last_im [NUM];
  int cnt_m;
  int vo_cnt;
  int fs_cnt;
  int vo0;
  int fs0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fit(input longint v);
    longint w;
    w = v & 64'sh7FFF;
    if (w >= 64'sd16384) w = w - 64'sd32768;
`ifdef TWIDDLE_SAT_EN
    if (v > 64'sd16383) w = 64'sd16383;
    else if (v < -64'sd16384) w = -64'sd16384;
    else w = v;
`endif
    return int'(w);
  endfunction

  function automatic void model_lane(input int beat, input int l, input int a, input int b,
                                     output int re, output int im);
    int     n;
    int     e;
    real    ang;
    longint c;
    longint s;
    longint pr;
    longint pq;
    n   = beat * NUM + l;
    e   = (n % 128) * (n / 128);
    ang = 2.0 * 3.14159265358979323846 * real'(e) / 512.0;
    c   = longint'($floor(1024.0 * $cos(ang) + 0.5));
    s   = longint'($floor(1024.0 * $sin(ang) + 0.5));
    pr  = longint'(a) * c + longint'(b) * s;
    pq  = longint'(b) * c - longint'(a) * s;
    re  = fit((pr + 64'sd512) >>> 10);
    im  = fit((pq + 64'sd512) >>> 10);
  endfunction

  task automatic tick();
    int re;
    int im;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i]  = 0;
        m_fs[i] = 0;
      end
      for (int l = 0; l < NUM; l++) begin
        last_re[l] = 0;
        last_im[l] = 0;
      end
      cnt_m = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_v[i]  = m_v[i-1];
        m_fs[i] = m_fs[i-1];
        for (int l = 0; l < NUM; l++) begin
          m_re[i][l] = m_re[i-1][l];
          m_im[i][l] = m_im[i-1][l];
        end
      end
      m_v[0]  = valid_in ? 1 : 0;
      m_fs[0] = (valid_in && cnt_m == 0) ? 1 : 0;
      if (valid_in) begin
        for (int l = 0; l < NUM; l++) begin
          model_lane(cnt_m, l, int'($signed(din_i[l])), int'($signed(din_q[l])), re, im);
          m_re[0][l] = re;
          m_im[0][l] = im;
        end
        cnt_m = (cnt_m + 1) % 32;
      end
      if (m_v[2] != 0) begin
        for (int l = 0; l < NUM; l++) begin
          last_re[l] = m_re[2][l];
          last_im[l] = m_im[2][l];
        end
      end
    end
    if (valid_out === 1'b1) vo_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    check("valid_out", int'(valid_out), m_v[2]);
    check("frame_start", int'(frame_start), m_fs[2]);
    for (int l = 0; l < NUM; l++) begin
      check($sformatf("do_re[%0d]", l), int'($signed(do_re[l])), last_re[l]);
      check($sformatf("do_im[%0d]", l), int'($signed(do_im[l])), last_im[l]);
    end
  endtask

  task automatic beat(input bit dir, input int a0, input int b0);
    valid_in = 1'b1;
    for (int l = 0; l < NUM; l++) begin
      din_i[l] = IW'($urandom_range(0, 32767));
      din_q[l] = IW'($urandom_range(0, 32767));
    end
    if (dir) begin
      din_i[0] = IW'(a0);
      din_q[0] = IW'(b0);
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    din_i    = '0;
    din_q    = '0;
    cnt_m    = 0;
    vo_cnt   = 0;
    fs_cnt   = 0;
    for (int i = 0; i < 3; i++) begin
      m_v[i]  = 0;
      m_fs[i] = 0;
    end
    tick();
    tick();
    rst = 1'b0;

    // beat 0: e=0 passes straight through
    beat(1'b1, 100, -50);
    idle(2);
    check("pass_re", int'($signed(do_re[0])), 100);
    check("pass_im", int'($signed(do_im[0])), -50);
    check("pass_vo", int'(valid_out), 1);
    check("pass_fs", int'(frame_start), 1);

    for (int k = 1; k < 18; k++) beat(1'b0, 0, 0);
    // beat 18: e=64, c=s=724, overflows the output range
    beat(1'b1, 16383, 16383);
    idle(2);
`ifdef TWIDDLE_SAT_EN
    check("ovf_re", int'($signed(do_re[0])), 16383);
`else
    check("ovf_re", int'($signed(do_re[0])), -9601);
`endif
    check("ovf_im", int'($signed(do_im[0])), 0);

    beat(1'b0, 0, 0);
    // beat 20: e=128, rotation by -j
    beat(1'b1, 1000, 200);
    idle(2);
    check("rot_re", int'($signed(do_re[0])), 200);
    check("rot_im", int'($signed(do_im[0])), -1000);
    for (int k = 21; k < 32; k++) beat(1'b0, 0, 0);
    idle(3);

    // gapped frame
    vo0 = vo_cnt;
    fs0 = fs_cnt;
    for (int k = 0; k < 32; k++) begin
      beat(1'b0, 0, 0);
      idle(1);
    end
    idle(3);
    check("gap_pulses", vo_cnt - vo0, 32);
    check("gap_fs", fs_cnt - fs0, 1);

    // reset mid-frame with beats in flight and valid_in held high
    for (int k = 0; k < 11; k++) beat(1'b0, 0, 0);
    rst      = 1'b1;
    valid_in = 1'b1;
    tick();
    rst      = 1'b0;
    valid_in = 1'b0;
    check("rst_vo", int'(valid_out), 0);
    idle(3);
    check("rst_idle_vo", int'(valid_out), 0);

    // two back-to-back frames starting from beat 0
    vo0 = vo_cnt;
    fs0 = fs_cnt;
    for (int k = 0; k < 64; k++) begin
      beat(1'b0, 0, 0);
      if (k == 2) check("post_rst_fs", int'(frame_start), 1);
    end
    idle(3);
    check("run_pulses", vo_cnt - vo0, 64);
    check("run_fs", fs_cnt - fs0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/twiddle_mul_stage1.md
TWIDDLE_MUL_STAGE1 -- requirements
Module: twiddle_mul_stage1

Interface
REQ-001 SHALL provide parameter IN_WIDTH, default 15, signed input sample width (matches butterfly11 output).
REQ-002 SHALL provide parameter OUT_WIDTH, default 15, signed output sample width.
REQ-003 SHALL provide parameter TW_WIDTH, default 12, signed twiddle width in Q1.10.
REQ-004 SHALL provide parameter NUM, default 16, samples per beat; DATA, default 32, beats per 512-point frame.
REQ-005 SHALL provide the following ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din_i  in  NUM x IN_WIDTH  real part per lane (signed).
- din_q  in  NUM x IN_WIDTH  imaginary part per lane (signed).
- valid_in  in  1  beat qualifier.
- do_re  out  NUM x OUT_WIDTH  real result per lane.
- do_im  out  NUM x OUT_WIDTH  imaginary result per lane.
- valid_out  out  1  result qualifier.
- frame_start  out  1  high with the first beat (beat 0) of each frame.

Function
REQ-006 SHALL keep a 5-bit beat counter cnt, incremented only on cycles with valid_in=1, wrapping 31->0; gaps in valid_in SHALL NOT advance it.
REQ-007 SHALL compute for lane l of beat cnt: n = cnt*NUM + l, e = (n mod 128) * (n div 128), range 0..381.
REQ-008 SHALL multiply each sample by W = cos(2*pi*e/512) - j*sin(2*pi*e/512), with c, s quantised round-to-nearest to Q1.10 (1.0 = 1024).
REQ-009 SHALL form re = a*c + b*s and im = b*c - a*s at full precision (IN_WIDTH+TW_WIDTH+1 bits), with no intermediate truncation.
REQ-010 SHALL round by adding 2^9, then arithmetic-shift right by 10.
REQ-011 SHALL have fixed latency 3: a valid_in beat at edge k appears with valid_out=1 after edge k+3; pipeline stages are input/ROM register, product register, sum/round/output register.
REQ-012 SHALL accept back-to-back beats at one per cycle, with no stall and no backpressure.
REQ-013 SHALL assert frame_start for the same output cycle as the beat that entered with cnt=0.
REQ-014 SHALL hold do_re/do_im at their last values while valid_out=0.

Reset
REQ-015 SHALL, on rst=1 at a clock edge, clear cnt, all pipeline valid bits, valid_out, frame_start, do_re and do_im to 0.
REQ-016 SHALL discard beats in flight when rst is asserted mid-frame; the first beat after reset release SHALL be treated as beat 0.
REQ-017 SHALL ignore valid_in while rst=1.

Configuration
REQ-018 With macro TWIDDLE_SAT_EN defined, each rounded result outside the OUT_WIDTH signed range SHALL clamp to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
REQ-019 Without TWIDDLE_SAT_EN, results SHALL wrap: keep the low OUT_WIDTH bits (two's complement).

Structure
REQ-020 SHALL place in shared package fft_pkg: FFT_N=512, TW_FRAC=10, the lane sample typedefs, and the twiddle typedef {c, s}.
REQ-021 SHALL implement the twiddle lookup as sub-module twiddle_rom: a 512-entry constant table indexed by e, registered output, one instance per lane.

Verification
REQ-022 Pass-through: beat 0, lane 0 = (100, -50), e=0 -> do_re=100, do_im=-50 three cycles later, with valid_out=1 and frame_start=1.
REQ-023 -j rotation: beat 20, lane 0 (n=320, e=128) = (1000, 200) -> (200, -1000).
REQ-024 Overflow at beat 18, lane 0 (n=288, e=64, c=s=724), input (16383, 16383) -> with TWIDDLE_SAT_EN: re=16383, im=0; without: re=-9601, im=0.
REQ-025 Gapped input: 32 beats with valid_in toggling 1/0 -> exactly 32 valid_out pulses, each 3 cycles after its input; frame_start only on the first; cnt wraps to 0 for the next frame.
REQ-026 Reset mid-frame: assert rst after beat 10 while 2 beats are in flight -> valid_out stays 0; the next input is treated as beat 0 (frame_start=1 on its output).
REQ-027 Continuous run: two back-to-back 512-point frames checked against a golden model -> bit-exact match, and frame_start high exactly every 32 output beats.
